myproject_mul_share_arb: RTL and testbench

- Time-shares one 15-bit-unsigned × 9-bit-signed multiplier core between NREQ requesters in the inference datapath.
- Each requester gets a valid/ready operand channel and a one-entry, valid/ready-buffered result channel.
- Round-robin arbitration. A tag pipeline routes each product back to its issuer.
- Sits between the dense-layer compute lanes and a single multiplier instance.

---
 rtl/myproject_mul_share_pkg.sv | 21 ++
 rtl/myproject_mul_15ns_9s_24_2_1.sv | 39 +++
 rtl/myproject_mul_share_arb.sv | 145 ++++++++++++++
 tb/tb_myproject_mul_share_arb.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/myproject_mul_share_pkg.sv
// rtl/myproject_mul_share_pkg.sv - shared constants and types for the multiplier share arbiter
// Purpose: requester count, operand/product widths, multiplier latency,
//          requester id type and the tag that travels alongside each product.
package myproject_mul_share_pkg;

  localparam int NREQ    = 4;   // number of requesters (2..8)
  localparam int AW      = 15;  // operand A width, unsigned
  localparam int BW      = 9;   // operand B width, signed
  localparam int PW      = 24;  // product width, signed
  localparam int MUL_LAT = 1;   // multiplier register stages

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef logic [IDW-1:0] req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } tag_t;

endpackage

// File: rtl/myproject_mul_15ns_9s_24_2_1.sv
// rtl/myproject_mul_15ns_9s_24_2_1.sv - unsigned x signed multiplier core, one output register
// Purpose: dout <= $signed({1'b0,din0}) * $signed(din1), registered once when ce is high.
// Ports:
//   clk   in   clock
//   ce    in   clock enable for the output register
//   din0  in   unsigned operand
//   din1  in   signed operand
//   dout  out  signed product, valid one cycle after the operands
module myproject_mul_15ns_9s_24_2_1 #(
  parameter int din0_WIDTH = 15,
  parameter int din1_WIDTH = 9,
  parameter int dout_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  ce,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic [dout_WIDTH-1:0] dout
);

  logic signed [dout_WIDTH-1:0] a_ext;
  logic signed [dout_WIDTH-1:0] b_ext;
  logic signed [dout_WIDTH-1:0] prod;

  // A is zero-extended, B sign-extended; the low dout_WIDTH bits of the
  // product are exact because the true result always fits.
  assign a_ext = dout_WIDTH'({1'b0, din0});
  assign b_ext = dout_WIDTH'($signed(din1));
  assign prod  = a_ext * b_ext;

  // Data register carries no reset: its contents only matter when a valid tag
  // accompanies it.
  always_ff @(posedge clk) begin
    if (ce) begin
      dout <= prod;
    end
  end

endmodule

// File: rtl/myproject_mul_share_arb.sv
// rtl/myproject_mul_share_arb.sv - round-robin time-sharing of one multiplier among NREQ requesters
// Purpose: arbitrates operand channels onto a single multiplier core, tracks the
//          issuing requester with a tag pipeline and returns each product into a
//          one-entry result buffer per requester.
// Ports:
//   clk        in   clock
//   reset      in   asynchronous active-low reset
//   req_valid  in   [NREQ]     operand valid per requester
//   req_ready  out  [NREQ]     operand accepted (one-hot or zero, combinational)
//   req_a      in   [NREQ*AW]  operand A, requester i at [i*AW +: AW]
//   req_b      in   [NREQ*BW]  operand B, requester i at [i*BW +: BW]
//   rsp_valid  out  [NREQ]     result buffer full
//   rsp_ready  in   [NREQ]     consumer accepts result
//   rsp_data   out  [NREQ*PW]  result, requester i at [i*PW +: PW]
//   busy       out  any product in flight or any result buffered
module myproject_mul_share_arb
  import myproject_mul_share_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*AW-1:0] req_a,
  input  logic [NREQ*BW-1:0] req_b,
  output logic [NREQ-1:0]    rsp_valid,
  input  logic [NREQ-1:0]    rsp_ready,
  output logic [NREQ*PW-1:0] rsp_data,
  output logic               busy
);

  req_id_t          ptr;
  tag_t             tag_pipe [MUL_LAT];
  logic [PW-1:0]    rsp_data_q [NREQ];

  logic [NREQ-1:0]  in_flight;
  logic [NREQ-1:0]  pop;
  logic [NREQ-1:0]  elig;
  logic             grant_valid;
  req_id_t          grant;
  int               idx;
  logic [AW-1:0]    a_mux;
  logic [BW-1:0]    b_mux;
  logic [PW-1:0]    product;
  tag_t             land_tag;
  logic             tags_busy;

  // Requesters that already have a product somewhere in the multiplier.
  always_comb begin
    in_flight = '0;
    tags_busy = 1'b0;
    for (int s = 0; s < MUL_LAT; s++) begin
      if (tag_pipe[s].valid) begin
        in_flight[tag_pipe[s].id] = 1'b1;
        tags_busy = 1'b1;
      end
    end
  end

  // A full buffer that is being popped this cycle counts as free: the new
  // product cannot land before the pop has taken effect.
  assign pop  = rsp_valid & rsp_ready;
  assign elig = req_valid & ~in_flight & (~rsp_valid | pop);

  // Round-robin search starting at ptr, wrapping past NREQ-1.
  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
    idx         = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!grant_valid && elig[idx]) begin
        grant_valid = 1'b1;
        grant       = req_id_t'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (reset && grant_valid) begin
      req_ready[grant] = 1'b1;
    end
  end

  assign a_mux = req_a[grant*AW +: AW];
  assign b_mux = req_b[grant*BW +: BW];

  myproject_mul_15ns_9s_24_2_1 #(
    .din0_WIDTH (AW),
    .din1_WIDTH (BW),
    .dout_WIDTH (PW)
  ) u_mul (
    .clk  (clk),
    .ce   (1'b1),
    .din0 (a_mux),
    .din1 (b_mux),
    .dout (product)
  );

  // Pointer and tag pipeline. Idle cycles push an invalid tag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
      for (int s = 0; s < MUL_LAT; s++) begin
        tag_pipe[s] <= '0;
      end
    end else begin
      if (grant_valid) begin
        ptr <= (grant == req_id_t'(NREQ - 1)) ? '0 : grant + 1'b1;
      end
      tag_pipe[0] <= '{valid: grant_valid, id: grant};
      for (int s = 1; s < MUL_LAT; s++) begin
        tag_pipe[s] <= tag_pipe[s-1];
      end
    end
  end

  assign land_tag = tag_pipe[MUL_LAT-1];

  // Result buffers: a landing product takes priority over a pop on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid <= '0;
      for (int i = 0; i < NREQ; i++) begin
        rsp_data_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (land_tag.valid && (land_tag.id == req_id_t'(i))) begin
          rsp_data_q[i] <= product;
          rsp_valid[i]  <= 1'b1;
        end else if (pop[i]) begin
          rsp_valid[i]  <= 1'b0;
        end
      end
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_rsp
    assign rsp_data[g*PW +: PW] = rsp_data_q[g];
  end

  assign busy = tags_busy | (|rsp_valid);

endmodule

// File: tb/tb_myproject_mul_share_arb.sv
// tb/tb_myproject_mul_share_arb.sv - directed self-checking bench for the multiplier share arbiter
module tb_myproject_mul_share_arb;
  import myproject_mul_share_pkg::*;

  logic               clk = 1'b0;
  logic               reset;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*AW-1:0] req_a;
  logic [NREQ*BW-1:0] req_b;
  logic [NREQ-1:0]    rsp_valid;
  logic [NREQ-1:0]    rsp_ready;
  logic [NREQ*PW-1:0] rsp_data;
  logic               busy;

  int checks = 0;
  int errors = 0;

  myproject_mul_share_arb dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_d(input string tag, input int i, input int exp);
    logic [PW-1:0] o;
    logic [PW-1:0] e;
    o = rsp_data[i*PW +: PW];
    e = exp[PW-1:0];
    chk(tag, {8'h00, o}, {8'h00, e});
  endtask

  task automatic set_op(input int i, input int a, input int b);
    req_a[i*AW +: AW] = a[AW-1:0];
    req_b[i*BW +: BW] = b[BW-1:0];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int exp2 [4] = '{300, 0, -8638, 8355585};

  initial begin
    reset     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = '0;

    // Reset state
    #2;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_rsp_data", 32'(|rsp_data), 32'h0);
    req_valid = '1;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    req_valid = '0;
    tick();
    tick();
    reset = 1'b1;

    // Single request: 32767 * -256
    set_op(0, 32767, -256);
    req_valid = 4'b0001;
    #1;
    chk("t1_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    #1;
    chk("t1_rv_c1", 32'(rsp_valid), 32'h0);
    chk("t1_busy_c1", 32'(busy), 32'h1);
    tick();
    chk("t1_rv_c2", 32'(rsp_valid), 32'h1);
    chk_d("t1_data", 0, -8388352);
    rsp_ready = 4'b0001;
    tick();
    chk("t1_rv_pop", 32'(rsp_valid), 32'h0);
    chk("t1_busy_end", 32'(busy), 32'h0);

    // Asynchronous reset pulse so the pointer restarts at 0
    reset = 1'b0;
    #1;
    reset = 1'b1;

    // All four requesters continuously valid
    set_op(0, 100, 3);
    set_op(1, 0, -1);
    set_op(2, 1234, -7);
    set_op(3, 32767, 255);
    req_valid = '1;
    rsp_ready = '1;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("t2_ready_%0d", k), 32'(req_ready), 32'(1) << (k % 4));
      if (k >= 2) begin
        chk($sformatf("t2_rv_%0d", k), 32'(rsp_valid), 32'(1) << ((k - 2) % 4));
        chk_d($sformatf("t2_data_%0d", k), (k - 2) % 4, exp2[(k - 2) % 4]);
      end else begin
        chk($sformatf("t2_rv_%0d", k), 32'(rsp_valid), 32'h0);
      end
      tick();
    end
    req_valid = '0;
    #1;
    chk("t2_drain_rv8", 32'(rsp_valid), 32'h4);
    tick();
    chk("t2_drain_rv9", 32'(rsp_valid), 32'h8);
    tick();
    chk("t2_drain_busy", 32'(busy), 32'h0);

    // Backpressure on requester 2
    rsp_ready = 4'b1011;
    set_op(2, 10, -3);
    req_valid = 4'b0100;
    #1;
    chk("t3_ready_c0", 32'(req_ready), 32'h4);
    tick();
    set_op(2, 20, 5);
    #1;
    chk("t3_ready_c1", 32'(req_ready), 32'h0);
    chk("t3_rv_c1", 32'(rsp_valid), 32'h0);
    tick();
    chk("t3_rv_c2", 32'(rsp_valid), 32'h4);
    chk_d("t3_data_c2", 2, -30);
    chk("t3_ready_c2", 32'(req_ready), 32'h0);
    tick();
    chk("t3_ready_c3", 32'(req_ready), 32'h0);
    chk_d("t3_data_c3", 2, -30);
    tick();
    chk("t3_ready_c4", 32'(req_ready), 32'h0);
    chk("t3_rv_c4", 32'(rsp_valid), 32'h4);
    rsp_ready = 4'b1111;
    #1;
    chk("t3_regrant", 32'(req_ready), 32'h4);
    tick();
    rsp_ready = 4'b1011;
    req_valid = '0;
    #1;
    chk("t3_rv_c5", 32'(rsp_valid), 32'h0);
    chk("t3_busy_c5", 32'(busy), 32'h1);
    tick();
    chk("t3_rv_c6", 32'(rsp_valid), 32'h4);
    chk_d("t3_data_c6", 2, 100);
    rsp_ready = '1;
    tick();
    chk("t3_rv_c7", 32'(rsp_valid), 32'h0);

    // Back-to-back reissue for requester 1; each result shown exactly once
    set_op(1, 7, -9);
    req_valid = 4'b0010;
    #1;
    chk("t4_ready_c0", 32'(req_ready), 32'h2);
    tick();
    set_op(1, 300, 100);
    #1;
    chk("t4_ready_c1", 32'(req_ready), 32'h0);
    chk("t4_rv_c1", 32'(rsp_valid), 32'h0);
    tick();
    chk("t4_rv_c2", 32'(rsp_valid), 32'h2);
    chk_d("t4_data_c2", 1, -63);
    chk("t4_ready_c2", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    #1;
    chk("t4_rv_c3", 32'(rsp_valid), 32'h0);
    tick();
    chk("t4_rv_c4", 32'(rsp_valid), 32'h2);
    chk_d("t4_data_c4", 1, 30000);
    tick();
    chk("t4_rv_c5", 32'(rsp_valid), 32'h0);
    chk("t4_busy_c5", 32'(busy), 32'h0);

    // Reset one cycle after issuing 5 * 7
    set_op(0, 5, 7);
    req_valid = 4'b0001;
    #1;
    chk("t5_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    reset = 1'b0;
    #1;
    chk("t5_rv_rst", 32'(rsp_valid), 32'h0);
    chk("t5_busy_rst", 32'(busy), 32'h0);
    req_valid = '1;
    #1;
    chk("t5_ready_rst", 32'(req_ready), 32'h0);
    tick();
    chk("t5_rv_rst2", 32'(rsp_valid), 32'h0);
    chk("t5_busy_rst2", 32'(busy), 32'h0);

    // Release; only requesters 1 and 3 valid -> 1,3,1,3 with wrap
    reset = 1'b1;
    set_op(1, 11, -11);
    set_op(3, 32767, -1);
    req_valid = 4'b1010;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("t6_ready_%0d", k), 32'(req_ready), (k % 2 == 0) ? 32'h2 : 32'h8);
      if (k >= 2) begin
        chk($sformatf("t6_rv_%0d", k), 32'(rsp_valid), (k % 2 == 0) ? 32'h2 : 32'h8);
        chk_d($sformatf("t6_data_%0d", k), (k % 2 == 0) ? 1 : 3, (k % 2 == 0) ? -121 : -32767);
      end else begin
        chk($sformatf("t6_rv_%0d", k), 32'(rsp_valid), 32'h0);
      end
      tick();
    end
    req_valid = '0;
    tick();
    tick();
    tick();
    chk("t6_busy_end", 32'(busy), 32'h0);
    chk("t6_rv_end", 32'(rsp_valid), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
